conv_tile_requant: RTL and testbench
====================================

Name: conv_tile_requant

Overview:
Downstream stage of the matrix convolution engine. Captures the 4x4 array of 16-bit accumulator results when the convolution pulses done. Applies bias, arithmetic right shift, ReLU and 8-bit saturation to each result. Streams the results out one element per handshake, row-major, toward the output writer / next-layer tile buffer.

Parameters:
TILE, 4, rows and columns of the result tile (results per tile = TILE*TILE)
ACC_W, 16, width of each unsigned accumulator result
OUT_W, 8, width of each unsigned activation output
BIAS_W, 16, width of the signed bias input

Ports:
clk  in  1  system clock (47.25 MHz domain)
rst  in  1  asynchronous reset, active-high
conv_done  in  1  one-cycle pulse from the convolution engine; the c array is valid in this cycle
c  in  TILE x TILE x ACC_W  unpacked result array [0:TILE-1][0:TILE-1], unsigned
bias  in  BIAS_W  signed bias, sampled at capture
shift  in  4  right-shift amount 0..15, sampled at capture
out_data  out  OUT_W  activation value
out_row  out  2  row index of out_data
out_col  out  2  column index of out_data
out_last  out  1  high with the final element (index TILE*TILE-1)
out_valid  out  1  output element valid
out_ready  in  1  downstream accept
busy  out  1  high from capture until the last element is accepted
tile_done  out  1  one-cycle pulse after the last element is accepted
drop_err  out  1  sticky flag: conv_done arrived while busy

Behaviour:
- Reset: all outputs are 0. State is IDLE, index is 0, capture buffer is cleared, drop_err is cleared.
- States:
  - IDLE: waits for conv_done.
  - STREAM: presents elements.
  - FINISH: one cycle; pulses tile_done, then returns to IDLE.
- IDLE + conv_done at edge N:
  - Copy all of c into the internal buffer; latch bias and shift.
  - Load element 0 into the output registers.
  - Go to STREAM.
  - At N+1: out_valid=1, busy=1. Latency from conv_done is one cycle.
- Per-element arithmetic:
  - s = zero-extended c (ACC_W+2 bits, signed) + sign-extended bias.
  - q = s >>> shift (arithmetic shift).
  - If q < 0, out = 0 (ReLU). If q > 2^OUT_W-1, out = 2^OUT_W-1. Otherwise out = q[OUT_W-1:0].
  - The computed value is registered into out_data.
- Handshake, AXI-stream style:
  - out_data, out_row, out_col and out_last are stable while out_valid && !out_ready.
  - A transfer occurs on an edge where out_valid && out_ready.
  - After a transfer of element i < 15, element i+1 is registered. out_valid stays high, so one element per cycle is sustained with out_ready tied high.
  - Ordering is row-major: index = row*TILE + col.
- Last element:
  - Element 15 carries out_last=1.
  - Its transfer moves the state to FINISH: out_valid=0, out_last=0, busy stays 1 for that cycle, tile_done=1.
  - Next cycle: IDLE, busy=0.
- A full tile with no backpressure takes 16 valid cycles plus 1 FINISH cycle, i.e. 17 cycles from the first valid.
- conv_done while busy (STREAM or FINISH):
  - Ignored. Buffer, bias and shift are unchanged.
  - drop_err is set and stays set until rst.
- c, bias and shift changing after capture have no effect on the tile in flight.
- rst mid-stream: immediate return to reset values, with no tile_done. The partially streamed tile is discarded.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro REQUANT_ROUND_EN.
- Defined: round-half-up before the shift. When shift>0, add 2^(shift-1) to s before q = s >>> shift; saturation and ReLU then apply. The adder is widened by 1 bit so the add cannot overflow.
- Undefined: truncating arithmetic shift only, with no extra adder.

Test Plan:
- All c=16'h0009, bias=0, shift=0, out_ready=1 → 16 outputs of 8'h09 on consecutive cycles starting 1 cycle after conv_done. Rows/cols run 0,0 through 3,3. out_last only on the 16th output. tile_done 1 cycle after it. busy high for 17 cycles.
- c[i][j]=i*4+j, bias=-5, shift=0 → outputs 0,0,0,0,0,0,1,2,...,10. ReLU clamps values 0..4 and 5 maps to 0.
- c=16'h1234, bias=0, shift=4 → 8'hFF (0x123 saturates). c=16'h0FF0, shift=4 → 8'hFF. c=16'h07F0, shift=4 → 8'h7F. With REQUANT_ROUND_EN: c=16'h0018, shift=4 → 8'h02; without it → 8'h01.
- Backpressure: out_ready toggles 1,0,0,1,... → no element is lost or duplicated. out_data/out_row/out_col are held while stalled. Sequence matches the no-stall run. tile_done only after the 16th accepted element.
- Second conv_done issued while element 5 is stalled → tile continues unchanged, drop_err=1 and sticky. After completion a new conv_done is accepted and streams normally.
- rst asserted asynchronously at element 7 → out_valid, busy and tile_done drop at once, with no tile_done pulse. After rst release the next conv_done streams a full fresh tile from index 0.

Source files
------------

// File: rtl/conv_tile_requant.sv
// conv_tile_requant
// Captures a TILE x TILE array of unsigned accumulator results on conv_done,
// then requantises each one (bias add, arithmetic right shift, ReLU, clamp to
// OUT_W bits) and streams the results row-major over a valid/ready handshake.
//
// Optional build macro: REQUANT_ROUND_EN
//   defined   -> round half up (add 2^(shift-1)) before the shift
//   undefined -> truncating arithmetic shift
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   conv_done         one-cycle capture strobe; c is valid in that cycle
//   c                 [0:TILE-1][0:TILE-1] unsigned accumulator results
//   bias, shift       signed bias and right-shift amount, sampled at capture
//   out_data          requantised activation
//   out_row, out_col  position of out_data in the tile
//   out_last          marks the final element of the tile
//   out_valid         out_data is valid
//   out_ready         downstream accept
//   busy              high from capture until the tile has fully drained
//   tile_done         one-cycle pulse after the last element is accepted
//   drop_err          sticky: conv_done arrived while busy
module conv_tile_requant #(
    parameter int unsigned TILE   = 4,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned BIAS_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     conv_done,
    input  logic [ACC_W-1:0]         c [0:TILE-1][0:TILE-1],
    input  logic signed [BIAS_W-1:0] bias,
    input  logic [3:0]               shift,
    output logic [OUT_W-1:0]         out_data,
    output logic [1:0]               out_row,
    output logic [1:0]               out_col,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     tile_done,
    output logic                     drop_err
);

    localparam int unsigned N_ELEM = TILE * TILE;
    localparam int unsigned IDX_W  = $clog2(N_ELEM);
    localparam int unsigned POS_W  = $clog2(TILE);
`ifdef REQUANT_ROUND_EN
    localparam int unsigned SUM_W  = ACC_W + 3;
`else
    localparam int unsigned SUM_W  = ACC_W + 2;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [ACC_W-1:0]          buf_q [0:TILE-1][0:TILE-1];
    logic signed [BIAS_W-1:0]  bias_q;
    logic [3:0]                shift_q;

    logic [IDX_W-1:0]          nxt_idx_c;
    logic [OUT_W-1:0]          nxt_data_c;

    // Bias, shift, ReLU and saturation for one accumulator value.
    function automatic logic [OUT_W-1:0] requant(
        input logic [ACC_W-1:0]         acc,
        input logic signed [BIAS_W-1:0] b,
        input logic [3:0]               sh
    );
        logic signed [SUM_W-1:0] s;
        logic signed [SUM_W-1:0] q;
        s = $signed({{(SUM_W-ACC_W){1'b0}}, acc}) + SUM_W'(b);
`ifdef REQUANT_ROUND_EN
        if (sh != 4'd0) begin
            s = s + (SUM_W'(1) <<< (sh - 4'd1));
        end
`endif
        q = s >>> sh;
        // Negative -> 0, anything above OUT_W bits -> all ones.
        if (q[SUM_W-1]) begin
            requant = '0;
        end else if (|q[SUM_W-2:OUT_W]) begin
            requant = '1;
        end else begin
            requant = q[OUT_W-1:0];
        end
    endfunction

    // Element following the one currently presented, taken from the buffer.
    always_comb begin
        nxt_idx_c  = idx_q + IDX_W'(1);
        nxt_data_c = requant(buf_q[nxt_idx_c[IDX_W-1:POS_W]][nxt_idx_c[POS_W-1:0]],
                             bias_q, shift_q);
    end

    // Control FSM with capture buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            bias_q    <= '0;
            shift_q   <= '0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            tile_done <= 1'b0;
            drop_err  <= 1'b0;
            for (int r = 0; r < int'(TILE); r++) begin
                for (int k = 0; k < int'(TILE); k++) begin
                    buf_q[r][k] <= '0;
                end
            end
        end else begin
            tile_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (conv_done) begin
                        buf_q     <= c;
                        bias_q    <= bias;
                        shift_q   <= shift;
                        // Element 0 comes straight from the inputs so it is
                        // presented one cycle after conv_done.
                        out_data  <= requant(c[0][0], bias, shift);
                        out_row   <= '0;
                        out_col   <= '0;
                        out_last  <= (LAST_IDX == '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        idx_q     <= '0;
                        state_q   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (conv_done) begin
                        drop_err <= 1'b1;
                    end
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            tile_done <= 1'b1;
                            state_q   <= ST_FINISH;
                        end else begin
                            idx_q    <= nxt_idx_c;
                            out_data <= nxt_data_c;
                            out_row  <= 2'(nxt_idx_c[IDX_W-1:POS_W]);
                            out_col  <= 2'(nxt_idx_c[POS_W-1:0]);
                            out_last <= (nxt_idx_c == LAST_IDX);
                        end
                    end
                end
                ST_FINISH: begin
                    if (conv_done) begin
                        drop_err <= 1'b1;
                    end
                    busy    <= 1'b0;
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_requant.sv
// Testbench for conv_tile_requant: directed tiles with a scoreboard queue of
// expected elements, pushed at capture and popped on each accepted transfer.
module tb_conv_tile_requant;

    logic              clk = 1'b0;
    logic              rst;
    logic              conv_done;
    logic [15:0]       c [0:3][0:3];
    logic signed [15:0] bias;
    logic [3:0]        shift;
    logic [7:0]        out_data;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              tile_done;
    logic              drop_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] r;
        logic [1:0] col;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   tile_v [0:3][0:3];

    always #5 clk = ~clk;

    conv_tile_requant dut (
        .clk       (clk),
        .rst       (rst),
        .conv_done (conv_done),
        .c         (c),
        .bias      (bias),
        .shift     (shift),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .tile_done (tile_done),
        .drop_err  (drop_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference requantisation in plain integer arithmetic.
    function automatic logic [7:0] model(input int acc, input int b, input int sh);
        int s;
        s = acc + b;
`ifdef REQUANT_ROUND_EN
        if (sh > 0) s = s + (1 << (sh - 1));
`endif
        s = s >>> sh;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                tile_v[i][j] = int'($urandom_range(0, 65535));
    endtask

    // Drive a tile, push its expected stream, pulse conv_done, then scramble
    // the inputs so later changes must not affect the captured tile.
    task automatic load_tile(input int bias_v, input int shift_v);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                c[i][j] = 16'(tile_v[i][j]);
                e.d   = model(tile_v[i][j], bias_v, shift_v);
                e.r   = 2'(i);
                e.col = 2'(j);
                e.l   = (i == 3 && j == 3);
                sb.push_back(e);
            end
        end
        bias      = 16'(bias_v);
        shift     = 4'(shift_v);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c[i][j] = 16'($urandom);
        bias  = 16'($urandom);
        shift = 4'($urandom);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_busy", 32'(busy), 32'd1);
    endtask

    // rmode 0: ready always high; rmode 1: ready pattern 1,0,0 repeating.
    task automatic stream(input int rmode, input int drop_at, input int stop_at);
        int   cyc;
        int   acc;
        bit   dropped;
        exp_t e;
        cyc = 0;
        acc = 0;
        dropped = 1'b0;
        while (acc < stop_at && cyc < 200) begin
            out_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
            chk("busy_stream", 32'(busy), 32'd1);
            chk("tile_done_early", 32'(tile_done), 32'd0);
            chk("valid_stream", 32'(out_valid), 32'd1);
            if (out_ready) begin
                e = sb.pop_front();
                chk("data", 32'(out_data), 32'(e.d));
                chk("row", 32'(out_row), 32'(e.r));
                chk("col", 32'(out_col), 32'(e.col));
                chk("last", 32'(out_last), 32'(e.l));
                acc++;
            end else begin
                e = sb[0];
                chk("hold_data", 32'(out_data), 32'(e.d));
                chk("hold_rowcol", 32'({out_row, out_col}), 32'({e.r, e.col}));
                if (drop_at == acc && !dropped) begin
                    conv_done = 1'b1;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            c[i][j] = 16'($urandom);
                    bias  = 16'($urandom);
                    shift = 4'($urandom);
                    dropped = 1'b1;
                end
            end
            @(negedge clk);
            conv_done = 1'b0;
            cyc++;
        end
        chk("stream_count", 32'(acc), 32'(stop_at));
    endtask

    task automatic finish_chk();
        chk("fin_valid", 32'(out_valid), 32'd0);
        chk("fin_last", 32'(out_last), 32'd0);
        chk("fin_tile_done", 32'(tile_done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd1);
        chk("fin_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("idle_tile_done", 32'(tile_done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        conv_done = 1'b0;
        out_ready = 1'b0;
        bias      = '0;
        shift     = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c[i][j] = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tile_done", 32'(tile_done), 32'd0);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        chk("rst_outs", 32'({out_data, out_row, out_col, out_last}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Constant tile of 9, no backpressure.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                tile_v[i][j] = 9;
        load_tile(0, 0);
        stream(0, -1, 16);
        finish_chk();

        // Ramp with negative bias: ReLU region.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                tile_v[i][j] = i * 4 + j;
        load_tile(-5, 0);
        stream(0, -1, 16);
        finish_chk();

        // Shift and saturation corners.
        for (int i = 0; i < 4; i++) begin
            tile_v[i][0] = 'h1234;
            tile_v[i][1] = 'h0FF0;
            tile_v[i][2] = 'h07F0;
            tile_v[i][3] = 'h0018;
        end
        load_tile(0, 4);
        stream(0, -1, 16);
        finish_chk();

        // Extreme bias corners.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                tile_v[i][j] = (j < 2) ? 'hFFFF : 0;
        load_tile(-32768, 0);
        stream(0, -1, 16);
        finish_chk();
        load_tile(32767, 7);
        stream(0, -1, 16);
        finish_chk();

        // Random tile under backpressure.
        fill_random();
        load_tile(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)));
        stream(1, -1, 16);
        finish_chk();
        chk("drop_err_clear", 32'(drop_err), 32'd0);

        // conv_done while element 5 is stalled is dropped and flagged.
        fill_random();
        load_tile(-1000, 6);
        stream(1, 5, 16);
        finish_chk();
        chk("drop_err_set", 32'(drop_err), 32'd1);

        // Next tile is accepted normally; flag stays sticky.
        fill_random();
        load_tile(500, 8);
        stream(0, -1, 16);
        finish_chk();
        chk("drop_err_sticky", 32'(drop_err), 32'd1);

        // Asynchronous reset while element 7 is presented.
        fill_random();
        load_tile(0, 9);
        stream(0, -1, 7);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tile_done", 32'(tile_done), 32'd0);
        chk("arst_drop_err", 32'(drop_err), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tile_done", 32'(tile_done), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        // Fresh tile after reset starts at index 0.
        fill_random();
        load_tile(-200, 3);
        stream(1, -1, 16);
        finish_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
